// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Read-side engine for the parallel-read FIFO datapath. While the FIFO reports
// at least PAR_READ words (empty=0), it pulses enr to take one group of
// PAR_READ words from the FIFO's combinational read port. It then sends the
// group one word at a time on a valid/ready stream, oldest word first.
//
// Stream handshake: a word moves on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid is raised, it and out_data stay constant
// until that transfer happens. out_valid never depends on out_ready.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   empty       FIFO empty flag (fewer than PAR_READ words available)
//   fifo_data   FIFO read port; slice [DATA_WIDTH-1:0] is the oldest word
//   enr         FIFO read enable; the FIFO advances PAR_READ words on this edge
//   out_data    stream data
//   out_valid   stream valid
//   out_ready   downstream ready
//   busy        high while a group is held (the FSM is in SEND). This port
//               also exposes the FSM state.
//   word_count  (FIFO_READER_COUNT_EN only) stream transfers, 16-bit, wraps
//   group_count (FIFO_READER_COUNT_EN only) enr edges, 16-bit, wraps
//
// Optional feature: define FIFO_READER_COUNT_EN to add the two counters.
// -----------------------------------------------------------------------------
module fifo_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_READ   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         empty,
    input  logic [DATA_WIDTH*PAR_READ-1:0] fifo_data,
    output logic                         enr,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [15:0]                  word_count,
    output logic [15:0]                  group_count
`endif
);

    localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                         state, state_next;
    logic [IDX_W-1:0]               idx, idx_next;
    logic [DATA_WIDTH*PAR_READ-1:0] hold, hold_next;
    logic                           xfer;
    logic                           last;
    logic                           load;

    // Next-state logic. A reload is allowed on the same edge that the last
    // held word leaves. This keeps the stream at one word per cycle with no
    // gap between groups.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        hold_next  = hold;
        out_valid  = (state == SEND);
        xfer       = out_valid && out_ready;
        last       = (idx == LAST_IDX);
        load       = !empty && ((state == IDLE) || (xfer && last));

        if (load) begin
            hold_next  = fifo_data;
            idx_next   = '0;
            state_next = SEND;
        end else if (xfer) begin
            if (last) begin
                state_next = IDLE;
                idx_next   = '0;
            end else begin
                idx_next = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            hold  <= hold_next;
        end
    end

    // Gating enr with rst keeps the FIFO pointer still while reset is held,
    // even if empty is already low.
    assign enr  = load && !rst;
    assign busy = out_valid;

    // out_data is selected from registers only. out_ready has no path to it.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < PAR_READ; i++) begin
            if (idx == IDX_W'(i)) begin
                out_data = hold[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef FIFO_READER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count  <= '0;
            group_count <= '0;
        end else begin
            if (xfer) begin
                word_count <= word_count + 16'd1;
            end
            if (load) begin
                group_count <= group_count + 16'd1;
            end
        end
    end
`endif

endmodule
